// File: rtl/sha256_hdr_seq.sv
// Sequences an external SHA-256 compression core over an 80-byte header; SHA256_HDR_DOUBLE_EN adds the second hash.
// Latency: done 137 cycles after start (205 with SHA256_HDR_DOUBLE_EN), 68 cycles per core pass.
// Backpressure: none; start is a request sampled only in IDLE, and starts while busy are dropped.
module sha256_hdr_seq (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [639:0] header,
    output logic         busy,
    output logic         done,
    output logic [255:0] digest,
    output logic         core_enable,
    output logic [511:0] core_data,
    output logic [255:0] core_current_hash,
    input  logic [255:0] core_hash,
    input  logic         core_hash_done
);
    localparam logic [255:0] SHA_IV =
        256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

    typedef enum logic [2:0] {
        IDLE,
        LOAD1,
        WAIT1,
        LOAD2,
        WAIT2,
`ifdef SHA256_HDR_DOUBLE_EN
        LOAD3,
        WAIT3,
`endif
        FIN
    } state_t;

    state_t       state;
    state_t       state_nxt;
    logic         hdr_ld;
    logic         h1_ld;
    logic         dig_ld;
    logic [639:0] hdr_q;
    logic [255:0] h1_q;
    logic [255:0] digest_q;
`ifdef SHA256_HDR_DOUBLE_EN
    logic         h2_ld;
    logic [255:0] h2_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // core_hash_done is a level that stays high into the next LOAD, so only WAIT states look at it
    always_comb begin
        state_nxt   = state;
        busy        = 1'b1;
        done        = 1'b0;
        core_enable = 1'b0;
        hdr_ld      = 1'b0;
        h1_ld       = 1'b0;
        dig_ld      = 1'b0;
`ifdef SHA256_HDR_DOUBLE_EN
        h2_ld       = 1'b0;
`endif
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    hdr_ld    = 1'b1;
                    state_nxt = LOAD1;
                end
            end
            LOAD1: begin
                core_enable = 1'b1;
                state_nxt   = WAIT1;
            end
            WAIT1: begin
                if (core_hash_done) begin
                    h1_ld     = 1'b1;
                    state_nxt = LOAD2;
                end
            end
            LOAD2: begin
                core_enable = 1'b1;
                state_nxt   = WAIT2;
            end
            WAIT2: begin
                if (core_hash_done) begin
`ifdef SHA256_HDR_DOUBLE_EN
                    h2_ld     = 1'b1;
                    state_nxt = LOAD3;
`else
                    dig_ld    = 1'b1;
                    state_nxt = FIN;
`endif
                end
            end
`ifdef SHA256_HDR_DOUBLE_EN
            LOAD3: begin
                core_enable = 1'b1;
                state_nxt   = WAIT3;
            end
            WAIT3: begin
                if (core_hash_done) begin
                    dig_ld    = 1'b1;
                    state_nxt = FIN;
                end
            end
`endif
            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Block 2 carries the header tail, the 0x80 pad byte, zero fill and the 640-bit length
    always_comb begin
        core_data         = hdr_q[639:128];
        core_current_hash = SHA_IV;
        case (state)
            LOAD2, WAIT2: begin
                core_data         = {hdr_q[127:0], 32'h8000_0000, 288'd0, 64'd640};
                core_current_hash = h1_q;
            end
`ifdef SHA256_HDR_DOUBLE_EN
            LOAD3, WAIT3: begin
                core_data         = {h2_q, 32'h8000_0000, 160'd0, 64'd256};
                core_current_hash = SHA_IV;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hdr_q    <= '0;
            h1_q     <= '0;
            digest_q <= '0;
`ifdef SHA256_HDR_DOUBLE_EN
            h2_q     <= '0;
`endif
        end else begin
            if (hdr_ld) hdr_q <= header;
            if (h1_ld) h1_q <= core_hash;
`ifdef SHA256_HDR_DOUBLE_EN
            if (h2_ld) h2_q <= core_hash;
`endif
            if (dig_ld) digest_q <= core_hash;
        end
    end

    assign digest = digest_q;

endmodule
